// File: rtl/gametext_pkg.sv
// Shared definitions for the on-screen text overlay sequencer.
//   - Screen-state encoding (TITLE / PLAY / OVER).
//   - Bit positions of the region-enable mask driven to the text renderer.
//   - BCD digit width and the countdown/enable helper functions.
package gametext_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    TITLE = 2'b00,
    PLAY  = 2'b01,
    OVER  = 2'b10
  } state_e;

  // Region-enable bit indices inside text_en
  localparam int EN_SCORE  = 3;
  localparam int EN_TITLE  = 2;
  localparam int EN_PROMPT = 1;
  localparam int EN_OVER   = 0;

  // One-second BCD decrement of {min, tens, ones}; saturates at 0:00
  function automatic logic [3*DIGIT_W-1:0] bcd_dec(input logic [3*DIGIT_W-1:0] t);
    logic [DIGIT_W-1:0] m;
    logic [DIGIT_W-1:0] tn;
    logic [DIGIT_W-1:0] o;
    {m, tn, o} = t;
    if (t == 12'h000) begin
      o = 4'd0;
    end else if (o != 4'd0) begin
      o = o - 4'd1;
    end else begin
      o = 4'd9;
      if (tn != 4'd0) begin
        tn = tn - 4'd1;
      end else begin
        tn = 4'd5;
        m  = m - 4'd1;
      end
    end
    return {m, tn, o};
  endfunction

  // Region-enable mask for a given screen state
  function automatic logic [3:0] text_en_of(input state_e s, input logic blink);
    logic [3:0] en;
    en = 4'b0000;
    case (s)
      TITLE: begin
        en[EN_TITLE]  = 1'b1;
        en[EN_PROMPT] = blink;
      end
      PLAY: begin
        en[EN_SCORE] = 1'b1;
      end
      OVER: begin
        en[EN_SCORE]  = 1'b1;
        en[EN_PROMPT] = 1'b1;
        en[EN_OVER]   = 1'b1;
      end
      default: begin
        en[EN_TITLE]  = 1'b1;
        en[EN_PROMPT] = 1'b1;
      end
    endcase
    return en;
  endfunction

endpackage

// File: rtl/gametext_sec_tick_gen.sv
// sec_tick_gen: free-running prescaler that counts 0..CLK_HZ-1 and flags
// the wrap cycle. Used for the one-second tick and for the prompt blink.
//   clk   in  clock
//   reset in  synchronous active-low reset
//   clr   in  restart the count at 0 on the next edge
//   tick  out high during the cycle in which the count is at CLK_HZ-1
module sec_tick_gen #(
  parameter int CLK_HZ = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Next count: restart on clear or wrap, otherwise advance
  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gametext_ctrl.sv
// gametext_ctrl: screen-state sequencer for the text overlay.
// Runs TITLE -> PLAY -> OVER -> TITLE, the BCD countdown shown in the score
// region, the game-over hold timer and the region-enable mask.
//   clk          in  pixel clock
//   reset        in  synchronous active-low reset
//   btn_start    in  debounced start button level
//   player_dead  in  game-logic death level
//   timer_min    out BCD minutes digit
//   timer_sec_t  out BCD tens-of-seconds digit
//   timer_sec_o  out BCD ones-of-seconds digit
//   text_en      out region enables {score, title, prompt, over}
//   game_state   out 00 TITLE, 01 PLAY, 10 OVER
//   time_up      out one-cycle pulse when the countdown reaches 0:00
module gametext_ctrl
  import gametext_pkg::*;
#(
  parameter int CLK_HZ    = 25_000_000,
  parameter int START_MIN = 3,
  parameter int START_SEC = 0,
  parameter int OVER_SECS = 5,
  parameter int BLINK_CYC = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       player_dead,
  output logic [3:0] timer_min,
  output logic [3:0] timer_sec_t,
  output logic [3:0] timer_sec_o,
  output logic [3:0] text_en,
  output logic [1:0] game_state,
  output logic       time_up
);

  localparam logic [3*DIGIT_W-1:0] LOAD_VAL = {4'(START_MIN), 4'(START_SEC / 10), 4'(START_SEC % 10)};
  localparam logic [7:0]           HOLD_LIM = 8'(OVER_SECS);

  state_e                 state_q, state_d;
  logic [3*DIGIT_W-1:0]   timer_q, timer_d;
  logic [7:0]             hold_q, hold_d;
  logic                   blink_q, blink_d;
  logic                   time_up_q, time_up_d;
  logic [3:0]             text_en_q, text_en_d;
  logic                   btn_q;

  logic                   start_rise;
  logic                   state_chg;
  logic                   sec_tick;
  logic                   blink_tick;
  logic [3*DIGIT_W-1:0]   timer_dec;
  logic [7:0]             hold_inc;

  assign start_rise = btn_start & ~btn_q;
  assign state_chg  = (state_d != state_q);
  assign timer_dec  = bcd_dec(timer_q);
  assign hold_inc   = hold_q + 8'd1;

  // Both prescalers restart on every state change so each state sees a
  // full period before its first tick.
  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_sec_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (state_chg),
    .tick  (sec_tick)
  );

  sec_tick_gen #(.CLK_HZ(BLINK_CYC)) u_blink_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (state_chg),
    .tick  (blink_tick)
  );

  // Next-state, countdown and hold-counter decode
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    hold_d    = hold_q;
    time_up_d = 1'b0;
    case (state_q)
      TITLE: begin
        hold_d = 8'd0;
        if (start_rise) begin
          state_d = PLAY;
          timer_d = LOAD_VAL;
        end else begin
          state_d = TITLE;
        end
      end
      PLAY: begin
        hold_d = 8'd0;
        // The final tick wins over player_dead so time_up still fires; a
        // 0:00 load also lands here on its first tick since bcd_dec saturates.
        if (sec_tick && (timer_dec == 12'h000)) begin
          timer_d   = 12'h000;
          time_up_d = 1'b1;
          state_d   = OVER;
        end else if (player_dead) begin
          state_d = OVER;
        end else if (sec_tick) begin
          timer_d = timer_dec;
        end else begin
          timer_d = timer_q;
        end
      end
      OVER: begin
        if (start_rise || (sec_tick && (hold_inc >= HOLD_LIM))) begin
          state_d = TITLE;
          hold_d  = 8'd0;
        end else if (sec_tick) begin
          hold_d = hold_inc;
        end else begin
          hold_d = hold_q;
        end
      end
      default: begin
        state_d = TITLE;
        hold_d  = 8'd0;
      end
    endcase
  end

  // Prompt blink: forced on at TITLE entry, otherwise toggles on its tick
  always_comb begin
    blink_d = blink_q;
    if ((state_d == TITLE) && (state_q != TITLE)) begin
      blink_d = 1'b1;
    end else if (blink_tick) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
    text_en_d = text_en_of(state_d, blink_d);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= TITLE;
      timer_q   <= LOAD_VAL;
      hold_q    <= 8'd0;
      blink_q   <= 1'b1;
      time_up_q <= 1'b0;
      text_en_q <= 4'b0110;
      btn_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      blink_q   <= blink_d;
      time_up_q <= time_up_d;
      text_en_q <= text_en_d;
      btn_q     <= btn_start;
    end
  end

  assign timer_min   = timer_q[11:8];
  assign timer_sec_t = timer_q[7:4];
  assign timer_sec_o = timer_q[3:0];
  assign text_en     = text_en_q;
  assign game_state  = state_q;
  assign time_up     = time_up_q;

endmodule

// File: doc/gametext_ctrl.md
# gametext_ctrl

Sequencer for the on-screen text overlay. Runs the screen-state machine (title → play → game over → title), the 3:00 countdown feeding the timer digits of the score region, and the per-region enable mask that gates the text renderer's region flags. Sits between the player/game-logic inputs and the text renderer, on the pixel clock.

## Interface

Parameters:
- CLK_HZ, 25_000_000, clock cycles per second tick
- START_MIN, 3, minutes loaded at game start (0–9)
- START_SEC, 0, seconds loaded at game start (0–59)
- OVER_SECS, 5, seconds the game-over screen holds before auto-return to title
- BLINK_CYC, 12_500_000, cycles per half-period of the title-screen prompt blink

Ports:
- clk  in  1  pixel clock; single clock domain
- reset  in  1  synchronous, active-low reset
- btn_start  in  1  start button level, already debounced and synchronised
- player_dead  in  1  level from game logic; ends the game while high
- timer_min  out  4  BCD minutes digit (X:00)
- timer_sec_t  out  4  BCD tens-of-seconds digit (0:X0)
- timer_sec_o  out  4  BCD ones-of-seconds digit (0:0X)
- text_en  out  4  region enables {score, title, prompt, over}; renderer ANDs with its region flags
- game_state  out  2  00 TITLE, 01 PLAY, 10 OVER
- time_up  out  1  one-cycle pulse when countdown reaches 0:00

## Operation

- Start edge: `btn_q` registers `btn_start`; `start_rise = btn_start & ~btn_q`. Holding the button produces exactly one edge.
- TITLE:
  - text_en = {0, 1, blink, 0}.
  - blink toggles every BLINK_CYC cycles and is forced to 1 on TITLE entry.
  - start_rise → PLAY; timer loads START_MIN:START_SEC; prescaler clears.
- PLAY:
  - text_en = {1, 0, 0, 0}.
  - Each second tick decrements the timer in BCD:
    - ones 0 → 9 with borrow from tens;
    - tens 0 → 5 with borrow from minutes.
  - The tick that takes the timer to 0:00 pulses time_up in that same cycle and moves to OVER.
  - player_dead high → OVER immediately; timer freezes at its current value.
  - If player_dead and the final tick coincide, go to OVER with time_up pulsed and the timer at 0:00.
  - start_rise is ignored.
- OVER:
  - text_en = {1, 0, 1, 1}; timer is frozen (final score shown).
  - A hold counter counts second ticks.
  - After OVER_SECS ticks, or on start_rise (whichever comes first), return to TITLE.
  - Timer digits hold until the next PLAY entry.
- Prescaler:
  - Counts 0..CLK_HZ-1 and emits a tick on wrap.
  - Cleared on every state change, so the first tick in each state comes a full CLK_HZ cycles after entry.
- Degenerate load: if START_MIN = 0 and START_SEC = 0, the first tick in PLAY pulses time_up and moves to OVER. No decrement below 0:00.
- Illegal game_state encoding 11 recovers to TITLE on the next clock.

## Timing

- Reset values (reset low at a clock edge):
  - game_state = TITLE, text_en = 4'b0110, timer digits = START_MIN, START_SEC tens, START_SEC ones.
  - time_up = 0, btn_q = 0, prescaler = 0, hold = 0, blink = 1.
- Reset asserted mid-game returns to TITLE on that edge regardless of state.
- All outputs are registered.
- If btn_start first samples high at edge N (with btn_q = 0), game_state = PLAY and the loaded timer are visible after edge N.
- In PLAY, a tick decided at edge N updates the digits after edge N. text_en follows game_state in the same cycle (decoded from the next-state value).
- player_dead sampled high at edge N gives game_state = OVER after edge N.
- In PLAY, second ticks occur every CLK_HZ cycles, the first at entry + CLK_HZ.

## Structure

- Shared package `gametext_pkg`:
  - state encoding constants (TITLE, PLAY, OVER);
  - text_en bit indices (EN_SCORE=3, EN_TITLE=2, EN_PROMPT=1, EN_OVER=0);
  - BCD digit width.
- One sub-module `sec_tick_gen` (parameter CLK_HZ; ports clk, reset, clr, tick). It is reused for the blink timer with parameter BLINK_CYC.
- FSM, BCD down-counter and hold counter live in `gametext_ctrl`.
- Target size is roughly 200 lines.

## Test plan

All scenarios use CLK_HZ=10, BLINK_CYC=4, OVER_SECS=2, START_MIN=0, START_SEC=12.

1. Reset low 3 cycles, then high → game_state=00, text_en=0110. prompt bit toggles every 4 cycles, i.e. 0110, then 0100 after 4 cycles.
2. btn_start held high 30 cycles → exactly one entry to PLAY. Digits 0,1,2; text_en=1000. After 10 cycles the digits read 0,1,1; after 30 cycles 0,0,9 (borrow).
3. Let the countdown run → after 120 cycles in PLAY: time_up pulses for one cycle, game_state=10, digits 0,0,0, text_en=1011. After a further 20 cycles: game_state=00.
4. player_dead pulsed 1 cycle at PLAY cycle 35 → OVER next edge, digits frozen at 0,0,9. A start_rise in OVER → TITLE next edge.
5. player_dead asserted on the same cycle as the final 0:01 → 0:00 tick → OVER with time_up=1 and digits 0,0,0.
6. reset low during PLAY at digits 0,0,5 → next edge: TITLE, digits 0,1,2, text_en=0110, time_up=0.
